// File: rtl/sdram_cpu_arbiter_if.sv
// Bundle of requester, controller and arbiter signals around the SDRAM CPU channel.
// master = requesters/controller side, slave = arbiter side.
interface sdram_cpu_arbiter_if;
    logic        clkref;
    logic        sd_busy;

    logic        ld_req;
    logic        ld_we;
    logic [23:1] ld_addr;
    logic [15:0] ld_din;
    logic [1:0]  ld_ds;
    logic        ld_ack;

    logic        cpu_req;
    logic        cpu_we;
    logic [23:1] cpu_addr;
    logic [15:0] cpu_din;
    logic [1:0]  cpu_ds;
    logic        cpu_ack;

    logic        bs_req;
    logic        bs_we;
    logic [19:0] bs_addr;
    logic [7:0]  bs_din;
    logic        bs_ack;

    logic [15:0] rdata;

    logic        sd_rd;
    logic        sd_wr;
    logic [23:1] sd_addr;
    logic [15:0] sd_din;
    logic [1:0]  sd_ds;
    logic [15:0] sd_dout;

    modport master (
        output clkref, sd_busy,
        output ld_req, ld_we, ld_addr, ld_din, ld_ds,
        input  ld_ack,
        output cpu_req, cpu_we, cpu_addr, cpu_din, cpu_ds,
        input  cpu_ack,
        output bs_req, bs_we, bs_addr, bs_din,
        input  bs_ack,
        input  rdata,
        input  sd_rd, sd_wr, sd_addr, sd_din, sd_ds,
        output sd_dout
    );

    modport slave (
        input  clkref, sd_busy,
        input  ld_req, ld_we, ld_addr, ld_din, ld_ds,
        output ld_ack,
        input  cpu_req, cpu_we, cpu_addr, cpu_din, cpu_ds,
        output cpu_ack,
        input  bs_req, bs_we, bs_addr, bs_din,
        output bs_ack,
        output rdata,
        output sd_rd, sd_wr, sd_addr, sd_din, sd_ds,
        input  sd_dout
    );
endinterface

// File: rtl/sdram_cpu_arbiter.sv
// Shares the SDRAM CPU channel between loader, SNES CPU and BSRAM, one access
// per clkref period; loader has strict priority, CPU/BSRAM alternate round-robin.
module sdram_cpu_arbiter #(
    parameter logic [23:0] BSRAM_BASE = 24'hF00000
) (
    input  logic                clk,
    input  logic                resetn,
    sdram_cpu_arbiter_if.slave  bus
);
    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    localparam logic [1:0] P_LD   = 2'd0;
    localparam logic [1:0] P_CPU  = 2'd1;
    localparam logic [1:0] P_BS   = 2'd2;
    localparam logic       RR_CPU = 1'b0;
    localparam logic       RR_BS  = 1'b1;
    localparam logic [3:0] BS_HI  = BSRAM_BASE[23:20];

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_clkref;
    logic [1:0]  r_gnt;
    logic        r_we;
    logic        r_bs_lsb;
    logic        r_rr;
    logic        r_sd_rd;
    logic        r_sd_wr;
    logic [23:1] r_sd_addr;
    logic [15:0] r_sd_din;
    logic [1:0]  r_sd_ds;
    logic [15:0] r_rdata;
    logic        r_ld_ack;
    logic        r_cpu_ack;
    logic        r_bs_ack;

    logic        w_rise;
    logic        w_ack_fire;
    logic        w_ld_elig;
    logic        w_cpu_elig;
    logic        w_bs_elig;
    logic        w_grant;
    logic [1:0]  w_sel;

    assign w_rise = bus.clkref & ~r_clkref;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_grant) w_state_nxt = S_ACTIVE;
            S_ACTIVE: if (w_rise)  w_state_nxt = w_grant ? S_ACTIVE : S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Ack/grant decisions; the port being acked sits out this edge's arbitration
    always_comb begin
        w_ack_fire = w_rise && (r_state == S_ACTIVE);
        w_ld_elig  = bus.ld_req  && !(w_ack_fire && (r_gnt == P_LD));
        w_cpu_elig = bus.cpu_req && !(w_ack_fire && (r_gnt == P_CPU));
        w_bs_elig  = bus.bs_req  && !(w_ack_fire && (r_gnt == P_BS));
        w_grant    = 1'b0;
        w_sel      = P_LD;
        if (w_rise && !bus.sd_busy) begin
            if (w_ld_elig) begin
                w_grant = 1'b1;
                w_sel   = P_LD;
            end else if (w_cpu_elig && (!w_bs_elig || (r_rr == RR_CPU))) begin
                w_grant = 1'b1;
                w_sel   = P_CPU;
            end else if (w_bs_elig) begin
                w_grant = 1'b1;
                w_sel   = P_BS;
            end
        end
    end

    // Datapath: ack/capture of the finishing access, then load of the new grant
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_clkref  <= 1'b0;
            r_gnt     <= P_LD;
            r_we      <= 1'b0;
            r_bs_lsb  <= 1'b0;
            r_rr      <= RR_CPU;
            r_sd_rd   <= 1'b0;
            r_sd_wr   <= 1'b0;
            r_sd_addr <= 23'd0;
            r_sd_din  <= 16'd0;
            r_sd_ds   <= 2'd0;
            r_rdata   <= 16'd0;
            r_ld_ack  <= 1'b0;
            r_cpu_ack <= 1'b0;
            r_bs_ack  <= 1'b0;
        end else begin
            r_clkref  <= bus.clkref;
            r_ld_ack  <= 1'b0;
            r_cpu_ack <= 1'b0;
            r_bs_ack  <= 1'b0;
            if (w_ack_fire) begin
                r_sd_rd   <= 1'b0;
                r_sd_wr   <= 1'b0;
                r_ld_ack  <= (r_gnt == P_LD);
                r_cpu_ack <= (r_gnt == P_CPU);
                r_bs_ack  <= (r_gnt == P_BS);
                if (!r_we) begin
                    if (r_gnt == P_BS)
                        r_rdata <= {8'h00, r_bs_lsb ? bus.sd_dout[15:8] : bus.sd_dout[7:0]};
                    else
                        r_rdata <= bus.sd_dout;
                end
            end
            if (w_grant) begin
                r_gnt <= w_sel;
                case (w_sel)
                    P_CPU: begin
                        r_we      <= bus.cpu_we;
                        r_sd_rd   <= ~bus.cpu_we;
                        r_sd_wr   <= bus.cpu_we;
                        r_sd_addr <= bus.cpu_addr;
                        r_sd_din  <= bus.cpu_din;
                        r_sd_ds   <= bus.cpu_ds;
                        r_rr      <= RR_BS;
                    end
                    P_BS: begin
                        r_we      <= bus.bs_we;
                        r_sd_rd   <= ~bus.bs_we;
                        r_sd_wr   <= bus.bs_we;
                        r_sd_addr <= {BS_HI, bus.bs_addr[19:1]};
                        r_sd_din  <= {bus.bs_din, bus.bs_din};
                        r_sd_ds   <= bus.bs_addr[0] ? 2'b10 : 2'b01;
                        r_bs_lsb  <= bus.bs_addr[0];
                        r_rr      <= RR_CPU;
                    end
                    default: begin
                        r_we      <= bus.ld_we;
                        r_sd_rd   <= ~bus.ld_we;
                        r_sd_wr   <= bus.ld_we;
                        r_sd_addr <= bus.ld_addr;
                        r_sd_din  <= bus.ld_din;
                        r_sd_ds   <= bus.ld_ds;
                    end
                endcase
            end
        end
    end

    assign bus.sd_rd   = r_sd_rd;
    assign bus.sd_wr   = r_sd_wr;
    assign bus.sd_addr = r_sd_addr;
    assign bus.sd_din  = r_sd_din;
    assign bus.sd_ds   = r_sd_ds;
    assign bus.rdata   = r_rdata;
    assign bus.ld_ack  = r_ld_ack;
    assign bus.cpu_ack = r_cpu_ack;
    assign bus.bs_ack  = r_bs_ack;
endmodule

// File: tb/tb_sdram_cpu_arbiter.sv
// Directed, table-driven bench for sdram_cpu_arbiter with a 4-clk clkref period.
// Rows are applied one clkref period apart and sampled just after each rise edge.
module tb_sdram_cpu_arbiter;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   phase = 3;
    int   checks = 0;
    int   failures = 0;

    sdram_cpu_arbiter_if bus_if ();

    sdram_cpu_arbiter #(.BSRAM_BASE(24'hF00000)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus_if)
    );

    always #5 clk = ~clk;

    // clkref: high for 2 clks, low for 2 clks, changing on falling clk edges
    initial begin
        bus_if.clkref = 1'b0;
        forever begin
            @(negedge clk);
            phase = (phase + 1) % 4;
            bus_if.clkref = (phase < 2);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        busy;
        logic        ldq;
        logic        ldwe;
        logic        cq;
        logic        cwe;
        logic [23:1] caddr;
        logic        bq;
        logic        bwe;
        logic [19:0] baddr;
        logic [7:0]  bdin;
        logic [15:0] dout;
        logic [2:0]  ack;
        logic        rd;
        logic        wr;
        logic [23:1] addr;
        logic [1:0]  ds;
        logic [15:0] din;
        logic [15:0] rdata;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_phase(input int p);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 8 && !hit; i++) begin
            @(negedge clk);
            #1;
            if (phase == p) hit = 1'b1;
        end
        if (!hit) begin
            failures++;
            $display("FAIL wait_phase: phase %0d not reached", p);
        end
    endtask

    // Advance to just after the next clkref rise edge seen by the DUT
    task automatic to_rise();
        wait_phase(0);
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        bus_if.sd_busy  = v.busy;
        bus_if.ld_req   = v.ldq;
        bus_if.ld_we    = v.ldwe;
        bus_if.cpu_req  = v.cq;
        bus_if.cpu_we   = v.cwe;
        bus_if.cpu_addr = v.caddr;
        bus_if.bs_req   = v.bq;
        bus_if.bs_we    = v.bwe;
        bus_if.bs_addr  = v.baddr;
        bus_if.bs_din   = v.bdin;
        bus_if.sd_dout  = v.dout;
    endtask

    function automatic logic [2:0] acks();
        return {bus_if.ld_ack, bus_if.cpu_ack, bus_if.bs_ack};
    endfunction

    initial begin
        // {busy,ldq,ldwe,cq,cwe,caddr,bq,bwe,baddr,bdin,dout, ack,rd,wr,addr,ds,din,rdata}
        vecs[0]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,23'h012345,1'b1,1'b0,20'h00002,8'h00,16'h1111, 3'b100,1'b1,1'b0,23'h012345,2'b11,16'hC0DE,16'h1111};
        vecs[1]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,23'h012345,1'b1,1'b0,20'h00002,8'h00,16'hBEEF, 3'b010,1'b1,1'b0,23'h780001,2'b01,16'h0000,16'hBEEF};
        vecs[2]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,23'h012345,1'b1,1'b0,20'h00002,8'h00,16'h1234, 3'b001,1'b1,1'b0,23'h012345,2'b11,16'hC0DE,16'h0034};
        vecs[3]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,23'h012345,1'b1,1'b1,20'h00003,8'h5A,16'h2222, 3'b010,1'b0,1'b1,23'h780001,2'b10,16'h5A5A,16'h2222};
        vecs[4]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,23'h7FFFFF,1'b1,1'b1,20'h00003,8'h5A,16'h3333, 3'b001,1'b1,1'b0,23'h7FFFFF,2'b11,16'hC0DE,16'h2222};
        vecs[5]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,23'h7FFFFF,1'b1,1'b0,20'h00002,8'h00,16'h4444, 3'b010,1'b0,1'b1,23'h000100,2'b11,16'hAAAA,16'h4444};
        vecs[6]  = '{1'b0,1'b1,1'b1,1'b1,1'b0,23'h012345,1'b1,1'b0,20'h00002,8'h00,16'h5555, 3'b100,1'b1,1'b0,23'h780001,2'b01,16'h0000,16'h4444};
        vecs[7]  = '{1'b0,1'b0,1'b0,1'b1,1'b0,23'h012345,1'b1,1'b0,20'h00002,8'h00,16'hA5C3, 3'b001,1'b1,1'b0,23'h012345,2'b11,16'hC0DE,16'h00C3};
        vecs[8]  = '{1'b1,1'b0,1'b0,1'b1,1'b0,23'h012345,1'b0,1'b0,20'h00003,8'h00,16'h6666, 3'b010,1'b0,1'b0,23'h000000,2'b00,16'h0000,16'h6666};
        vecs[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,23'h012345,1'b1,1'b0,20'h00003,8'h00,16'h7777, 3'b000,1'b0,1'b0,23'h000000,2'b00,16'h0000,16'h6666};
        vecs[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0,23'h012345,1'b1,1'b0,20'h00003,8'h00,16'h7777, 3'b000,1'b1,1'b0,23'h780001,2'b10,16'h0000,16'h6666};
        vecs[11] = '{1'b1,1'b0,1'b0,1'b0,1'b0,23'h012345,1'b1,1'b0,20'h00003,8'h00,16'hAB77, 3'b001,1'b0,1'b0,23'h000000,2'b00,16'h0000,16'h00AB};
        vecs[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0,23'h012345,1'b0,1'b0,20'h00003,8'h00,16'h8888, 3'b000,1'b0,1'b0,23'h000000,2'b00,16'h0000,16'h00AB};

        // Reset held with controller busy and every requester asking
        bus_if.ld_addr = 23'h000100;
        bus_if.ld_din  = 16'hAAAA;
        bus_if.ld_ds   = 2'b11;
        bus_if.cpu_din = 16'hC0DE;
        bus_if.cpu_ds  = 2'b11;
        apply(vecs[0]);
        bus_if.sd_busy = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("reset acks", 32'(acks()), 32'd0);
        chk("reset sd_rd/wr", 32'({bus_if.sd_rd, bus_if.sd_wr}), 32'd0);
        chk("reset sd_addr", 32'(bus_if.sd_addr), 32'd0);
        chk("reset sd_din/ds", 32'({bus_if.sd_din, bus_if.sd_ds}), 32'd0);
        chk("reset rdata", 32'(bus_if.rdata), 32'd0);
        wait_phase(2);
        resetn = 1'b1;

        for (int p = 0; p < 10; p++) begin
            to_rise();
            chk($sformatf("busy p%0d acks", p), 32'(acks()), 32'd0);
            chk($sformatf("busy p%0d sd_rd", p), 32'(bus_if.sd_rd), 32'd0);
        end
        bus_if.sd_busy = 1'b0;
        to_rise();
        chk("first grant sd_rd", 32'(bus_if.sd_rd), 32'd1);
        chk("first grant is loader", 32'(bus_if.sd_addr), 32'h000100);

        for (int i = 0; i < 13; i++) begin
            apply(vecs[i]);
            to_rise();
            chk($sformatf("row%0d acks", i), 32'(acks()), 32'(vecs[i].ack));
            chk($sformatf("row%0d rd/wr", i), 32'({bus_if.sd_rd, bus_if.sd_wr}),
                32'({vecs[i].rd, vecs[i].wr}));
            chk($sformatf("row%0d rdata", i), 32'(bus_if.rdata), 32'(vecs[i].rdata));
            if (vecs[i].rd || vecs[i].wr) begin
                chk($sformatf("row%0d sd_addr", i), 32'(bus_if.sd_addr), 32'(vecs[i].addr));
                chk($sformatf("row%0d sd_ds", i), 32'(bus_if.sd_ds), 32'(vecs[i].ds));
                chk($sformatf("row%0d sd_din", i), 32'(bus_if.sd_din), 32'(vecs[i].din));
            end
        end

        // Grant fields hold for the whole period; ack is a single-clk pulse
        bus_if.cpu_req  = 1'b1;
        bus_if.cpu_we   = 1'b0;
        bus_if.cpu_addr = 23'h055AA5;
        bus_if.sd_dout  = 16'h9ABC;
        to_rise();
        chk("hold grant sd_rd", 32'(bus_if.sd_rd), 32'd1);
        for (int k = 1; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("hold clk%0d sd_rd", k), 32'(bus_if.sd_rd), 32'd1);
            chk($sformatf("hold clk%0d sd_addr", k), 32'(bus_if.sd_addr), 32'h055AA5);
            chk($sformatf("hold clk%0d cpu_ack", k), 32'(bus_if.cpu_ack), 32'd0);
        end
        to_rise();
        chk("hold ack", 32'(acks()), 32'b010);
        chk("hold ack rd drop", 32'(bus_if.sd_rd), 32'd0);
        chk("hold ack rdata", 32'(bus_if.rdata), 32'h9ABC);
        bus_if.cpu_req = 1'b0;
        @(posedge clk);
        #1;
        chk("ack pulse width", 32'(bus_if.cpu_ack), 32'd0);

        // Reset in the middle of an active access
        bus_if.cpu_req  = 1'b1;
        bus_if.cpu_addr = 23'h00ABCD;
        to_rise();
        chk("pre-reset grant", 32'({bus_if.sd_rd, bus_if.sd_addr}), 32'({1'b1, 23'h00ABCD}));
        @(posedge clk);
        #1;
        resetn = 1'b0;
        #1;
        chk("async reset rd/wr", 32'({bus_if.sd_rd, bus_if.sd_wr}), 32'd0);
        chk("async reset sd_addr", 32'(bus_if.sd_addr), 32'd0);
        chk("async reset rdata", 32'(bus_if.rdata), 32'd0);
        wait_phase(2);
        resetn = 1'b1;
        to_rise();
        chk("post-reset no ack", 32'(acks()), 32'd0);
        chk("post-reset regrant", 32'({bus_if.sd_rd, bus_if.sd_addr}), 32'({1'b1, 23'h00ABCD}));
        to_rise();
        chk("post-reset ack", 32'(acks()), 32'b010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
